// File: rtl/jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_sequencer
// Purpose  : Shares one bank of W JK flip-flops among NREQ requesters.
//            It arbitrates round-robin, drives J/K for one clock, and then
//            acknowledges. It also sequences the bank's power-up clear.
// Options  : JKB_READBACK_EN - compare bank_Q against the expected result in
//            DONE and raise a sticky err flag on mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module jk_bank_sequencer #(
  parameter int W           = 8,
  parameter int NREQ        = 4,
  parameter int INIT_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                Clear,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   op,
  input  logic [W*NREQ-1:0]   mask,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic [W-1:0]        bank_J,
  output logic [W-1:0]        bank_K,
  output logic [W-1:0]        bank_Preset_n,
  output logic [W-1:0]        bank_Clear_n,
  input  logic [W-1:0]        bank_Q,
  output logic                busy,
  output logic                err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(INIT_CYCLES + 1);

  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] INIT_END  = CW'(INIT_CYCLES);
  localparam logic [PW-1:0] PTR_MAX   = PW'(NREQ - 1);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   init_cnt_q, init_cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [W-1:0]    j_q, j_d;
  logic [W-1:0]    k_q, k_d;
  logic [W-1:0]    clr_n_q, clr_n_d;
  logic [W-1:0]    pre_n_q;
  logic            busy_q, busy_d;

  logic            arb_any, arb_hi_any;
  logic [PW-1:0]   arb_lo_idx, arb_hi_idx, arb_idx;
  logic [1:0]      arb_op;
  logic [W-1:0]    arb_mask;
  logic [NREQ-1:0] arb_onehot, win_onehot;

  // Round-robin pick: lowest requester at/above the pointer, else lowest overall
  always_comb begin
    arb_any    = 1'b0;
    arb_hi_any = 1'b0;
    arb_lo_idx = '0;
    arb_hi_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        arb_any    = 1'b1;
        arb_lo_idx = PW'(i);
        if (PW'(i) >= ptr_q) begin
          arb_hi_any = 1'b1;
          arb_hi_idx = PW'(i);
        end
      end
    end
    arb_idx = arb_hi_any ? arb_hi_idx : arb_lo_idx;
  end

  // Route the candidate's op/mask and decode candidate/winner one-hot vectors
  always_comb begin
    arb_op     = '0;
    arb_mask   = '0;
    arb_onehot = '0;
    win_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == PW'(i)) begin
        arb_op        = op[2*i +: 2];
        arb_mask      = mask[W*i +: W];
        arb_onehot[i] = 1'b1;
      end
      if (win_q == PW'(i)) begin
        win_onehot[i] = 1'b1;
      end
    end
  end

  // State and registered outputs; Clear drops any pending operation
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      ptr_q      <= '0;
      win_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      j_q        <= '0;
      k_q        <= '0;
      clr_n_q    <= '0;
      pre_n_q    <= '1;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      j_q        <= j_d;
      k_q        <= k_d;
      clr_n_q    <= clr_n_d;
      pre_n_q    <= '1;
      busy_q     <= busy_d;
    end
  end

  // Next state, init counter, winner latch and pointer advance
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    case (state_q)
      S_INIT: begin
        if (init_cnt_q == INIT_END) begin
          state_d = S_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + CW'(1);
        end
      end
      S_IDLE: begin
        if (arb_any) begin
          state_d = S_ISSUE;
          win_d   = arb_idx;
        end
      end
      S_ISSUE: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = (win_q == PTR_MAX) ? '0 : win_q + PW'(1);
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    gnt_d   = '0;
    done_d  = '0;
    j_d     = '0;
    k_d     = '0;
    clr_n_d = clr_n_q;
    busy_d  = (state_d != S_IDLE);
    case (state_q)
      S_INIT: begin
        // Release the bank clear one cycle before leaving INIT
        if (init_cnt_q >= INIT_LAST) begin
          clr_n_d = '1;
        end
      end
      S_IDLE: begin
        if (arb_any) begin
          gnt_d = arb_onehot;
          // op[1] asserts J, op[0] asserts K on every masked bit
          j_d   = arb_op[1] ? arb_mask : '0;
          k_d   = arb_op[0] ? arb_mask : '0;
        end
      end
      S_ISSUE: begin
        done_d = win_onehot;
      end
      default: begin
      end
    endcase
  end

`ifdef JKB_READBACK_EN
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  logic [1:0]   op_q;
  logic [W-1:0] mask_q;
  logic [W-1:0] snap_q;
  logic [W-1:0] rb_exp;
  logic         rb_mismatch;
  logic         err_q;

  // Expected bank contents after the operation, checked only on masked bits
  always_comb begin
    case (op_q)
      OP_SET:    rb_exp = '1;
      OP_RESET:  rb_exp = '0;
      OP_TOGGLE: rb_exp = ~snap_q;
      default:   rb_exp = snap_q;
    endcase
    rb_mismatch = |((bank_Q ^ rb_exp) & mask_q);
  end

  // Latch the winner's command and pre-op bank value; sticky mismatch in DONE
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      op_q   <= '0;
      mask_q <= '0;
      snap_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && arb_any) begin
        op_q   <= arb_op;
        mask_q <= arb_mask;
        snap_q <= bank_Q;
      end
      if (state_q == S_DONE && rb_mismatch) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_bank_q;
  assign unused_bank_q = ^bank_Q;
  assign err           = 1'b0;
`endif

  assign gnt           = gnt_q;
  assign done          = done_q;
  assign bank_J        = j_q;
  assign bank_K        = k_q;
  assign bank_Preset_n = pre_n_q;
  assign bank_Clear_n  = clr_n_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_bank_sequencer
// Purpose  : Self-checking bench for jk_bank_sequencer with a behavioural
//            JK bank and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_bank_sequencer;

  localparam int W           = 8;
  localparam int NREQ        = 4;
  localparam int INIT_CYCLES = 2;

  logic                CLK;
  logic                Clear;
  logic [NREQ-1:0]     req;
  logic [2*NREQ-1:0]   op;
  logic [W*NREQ-1:0]   mask;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     done;
  logic [W-1:0]        bank_J;
  logic [W-1:0]        bank_K;
  logic [W-1:0]        bank_Preset_n;
  logic [W-1:0]        bank_Clear_n;
  logic [W-1:0]        bank_Q;
  logic                busy;
  logic                err;

  logic [W-1:0]        bq;
  logic                force_zero;

  int                  n_checks;
  int                  n_errors;
  int                  m_ptr;
  logic [W-1:0]        m_bank;
  logic                exp_err;

  jk_bank_sequencer #(
    .W           (W),
    .NREQ        (NREQ),
    .INIT_CYCLES (INIT_CYCLES)
  ) dut (
    .CLK           (CLK),
    .Clear         (Clear),
    .req           (req),
    .op            (op),
    .mask          (mask),
    .gnt           (gnt),
    .done          (done),
    .bank_J        (bank_J),
    .bank_K        (bank_K),
    .bank_Preset_n (bank_Preset_n),
    .bank_Clear_n  (bank_Clear_n),
    .bank_Q        (bank_Q),
    .busy          (busy),
    .err           (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural JK flip-flop bank with asynchronous active-low preset/clear
  always @(posedge CLK or negedge (&bank_Clear_n) or negedge (&bank_Preset_n)) begin
    if (!(&bank_Clear_n) || !(&bank_Preset_n))
      bq <= (bq | ~bank_Preset_n) & bank_Clear_n;
    else
      bq <= (bank_J & ~bq) | (~bank_K & bq);
  end

  assign bank_Q = force_zero ? '0 : bq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Release Clear and walk through INIT while requests are held high
  task automatic release_reset();
    req   = '1;
    op    = (2*NREQ)'($urandom);
    mask  = (W*NREQ)'($urandom);
    Clear = 1'b1;
    @(posedge CLK); #1;
    chk("init1_clrn", 32'(bank_Clear_n), 32'h00);
    chk("init1_gnt",  32'(gnt), 32'h0);
    chk("init1_busy", 32'(busy), 32'h1);
    @(posedge CLK); #1;
    chk("init2_clrn", 32'(bank_Clear_n), 32'hFF);
    chk("init2_gnt",  32'(gnt), 32'h0);
    chk("init2_busy", 32'(busy), 32'h1);
    @(posedge CLK); #1;
    chk("init3_busy", 32'(busy), 32'h0);
    chk("init3_gnt",  32'(gnt), 32'h0);
    chk("init3_bankq", 32'(bank_Q), 32'h00);
    req     = '0;
    m_ptr   = 0;
    m_bank  = '0;
    exp_err = 1'b0;
  endtask

  // One arbitration round; the model picks the winner from the rules directly
  task automatic do_op(input logic [NREQ-1:0] r, input logic [2*NREQ-1:0] o,
                       input logic [W*NREQ-1:0] m, input bit force_rb);
    int            win;
    logic [1:0]    wop;
    logic [W-1:0]  wm, ej, ek, nb;
    logic [NREQ-1:0] oh;
    req  = r;
    op   = o;
    mask = m;
    win  = -1;
    for (int k = 0; k < NREQ; k++)
      if (win < 0 && r[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
    @(posedge CLK); #1;
    if (win < 0) begin
      chk("noreq_gnt",  32'(gnt), 32'h0);
      chk("noreq_busy", 32'(busy), 32'h0);
      return;
    end
    wop = o[2*win +: 2];
    wm  = m[W*win +: W];
    oh  = NREQ'(1) << win;
    case (wop)
      2'b10:   begin ej = wm;  ek = '0; nb = m_bank | wm;  end
      2'b01:   begin ej = '0;  ek = wm; nb = m_bank & ~wm; end
      2'b11:   begin ej = wm;  ek = wm; nb = m_bank ^ wm;  end
      default: begin ej = '0;  ek = '0; nb = m_bank;       end
    endcase
    chk("issue_gnt",  32'(gnt), 32'(oh));
    chk("issue_j",    32'(bank_J), 32'(ej));
    chk("issue_k",    32'(bank_K), 32'(ek));
    chk("issue_done", 32'(done), 32'h0);
    chk("issue_busy", 32'(busy), 32'h1);
    // Inputs change after the grant decision; the DUT must ignore them
    req  = NREQ'($urandom) | oh;
    op   = (2*NREQ)'($urandom);
    mask = (W*NREQ)'($urandom);
    if (force_rb) force_zero = 1'b1;
    @(posedge CLK); #1;
    chk("done_done", 32'(done), 32'(oh));
    chk("done_gnt",  32'(gnt), 32'h0);
    chk("done_jk",   32'({bank_J, bank_K}), 32'h0);
    chk("done_bank", 32'(bank_Q), force_rb ? 32'h0 : 32'(nb));
    chk("done_busy", 32'(busy), 32'h1);
`ifdef JKB_READBACK_EN
    if (force_rb && ((nb & wm) != '0)) exp_err = 1'b1;
`endif
    @(posedge CLK); #1;
    force_zero = 1'b0;
    chk("idle_done",   32'(done), 32'h0);
    chk("idle_busy",   32'(busy), 32'h0);
    chk("idle_err",    32'(err), 32'(exp_err));
    chk("idle_preset", 32'(bank_Preset_n), 32'hFF);
    m_bank = nb;
    m_ptr  = (win + 1) % NREQ;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    Clear      = 1'b0;
    req        = '0;
    op         = '0;
    mask       = '0;
    force_zero = 1'b0;
    m_ptr      = 0;
    m_bank     = '0;
    exp_err    = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_gnt",    32'(gnt), 32'h0);
    chk("rst_done",   32'(done), 32'h0);
    chk("rst_jk",     32'({bank_J, bank_K}), 32'h0);
    chk("rst_preset", 32'(bank_Preset_n), 32'hFF);
    chk("rst_clrn",   32'(bank_Clear_n), 32'h00);
    chk("rst_busy",   32'(busy), 32'h1);
    chk("rst_err",    32'(err), 32'h0);

    release_reset();

    // Directed: set, toggle, hold to bring the pointer back to 0
    do_op(4'b0010, 8'b0000_1000, 32'h0000_0F00, 1'b0);
    do_op(4'b0100, 8'b0011_0000, 32'h00FF_0000, 1'b0);
    do_op(4'b1000, 8'b0000_0000, 32'hFF00_0000, 1'b0);

    // All requesters held: grants rotate 0,1,2,3,0 at 3-cycle spacing
    for (int i = 0; i < 5; i++)
      do_op(4'b1111, (2*NREQ)'($urandom), (W*NREQ)'($urandom), 1'b0);

    // Zero mask still completes a full grant/done round
    do_op(4'b0001, 8'b1111_1111, 32'h0, 1'b0);

    // Bank reads back wrong after a set on bit 0
    do_op(4'b0001, 8'b0000_0010, 32'h0000_0001, 1'b1);

    for (int i = 0; i < 25; i++)
      do_op(NREQ'($urandom), (2*NREQ)'($urandom), (W*NREQ)'($urandom), 1'b0);

    // Fill the bank, then interrupt an operation with Clear during ISSUE
    do_op(4'b0100, 8'b0010_0000, 32'h00FF_0000, 1'b0);
    req  = 4'b0010;
    op   = 8'b0000_1100;
    mask = 32'h0000_FF00;
    @(posedge CLK); #1;
    chk("mid_gnt_before", 32'(gnt), 32'h2);
    Clear = 1'b0;
    #1;
    chk("mid_gnt",   32'(gnt), 32'h0);
    chk("mid_jk",    32'({bank_J, bank_K}), 32'h0);
    chk("mid_done",  32'(done), 32'h0);
    chk("mid_busy",  32'(busy), 32'h1);
    chk("mid_clrn",  32'(bank_Clear_n), 32'h00);
    chk("mid_bankq", 32'(bank_Q), 32'h00);
    chk("mid_err",   32'(err), 32'h0);
    @(posedge CLK); #1;
    chk("mid_done2", 32'(done), 32'h0);
    release_reset();

    for (int i = 0; i < 8; i++)
      do_op(NREQ'($urandom), (2*NREQ)'($urandom), (W*NREQ)'($urandom), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
